time_counter: RTL and testbench
===============================

TIME_COUNTER -- requirements
Module: time_counter

Interface
REQ-001 SHALL have parameter SYNC_STAGES, default 2: synchronizer depth on clk_1hz, clk_fast, clk_blink, adj, sel (min 2).
REQ-002 SHALL have port clk  input  1  system clock; single clock domain for all state.
REQ-003 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-004 SHALL have port clk_1hz  input  1  divided 1 Hz level from clock divider; each rising edge = one second.
REQ-005 SHALL have port clk_fast  input  1  divided fast level; each rising edge = one adjust step.
REQ-006 SHALL have port clk_blink  input  1  divided blink level; high = blank phase.
REQ-007 SHALL have port adj  input  1  adjust-mode switch level.
REQ-008 SHALL have port sel  input  1  adjust target: 0 = minutes, 1 = seconds.
REQ-009 SHALL have port pause_pulse  input  1  single-cycle synchronous pulse (already debounced); toggles pause.
REQ-010 SHALL have ports min_tens, min_ones, sec_tens, sec_ones  output  4 each  BCD time digits.
REQ-011 SHALL have port digit_blank  output  4  blank mask: [3]=min_tens, [2]=min_ones, [1]=sec_tens, [0]=sec_ones; 1 = blank.
REQ-012 SHALL have port rollover  output  1  one-cycle pulse on 59:59 -> 00:00 in RUN.

Function
REQ-013 clk_1hz, clk_fast, clk_blink, adj, sel SHALL each pass through a SYNC_STAGES flop chain; no divided signal SHALL drive any flop clock pin.
REQ-014 Tick event = synchronized level high and previous-cycle synchronized level low; previous-level flops reset to 1 (no spurious event when input is high at reset release).
REQ-015 Digit outputs SHALL change exactly SYNC_STAGES+1 clk edges after the first edge sampling a tick input high.
REQ-016 State machine states RUN, PAUSE, ADJUST; registered, evaluated on current state value.
REQ-017 Synchronized adj=1 SHALL move any state to ADJUST; adj=0 in ADJUST SHALL go to PAUSE if paused flag set, else RUN.
REQ-018 pause_pulse SHALL toggle paused flag and move RUN<->PAUSE; ignored in ADJUST.
REQ-019 RUN: 1 Hz event increments seconds; 59 -> 00 with minute carry; 59:59 -> 00:00 asserts rollover for one cycle.
REQ-020 PAUSE: time frozen; 1 Hz and fast events ignored.
REQ-021 ADJUST: fast event increments selected field only, mod 60, no carry into other field, no rollover; 1 Hz events ignored.
REQ-022 Ones digits SHALL stay 0-9, tens digits 0-5, under all input sequences.
REQ-023 Same-cycle 1 Hz event and pause_pulse in RUN: increment applied and state goes to PAUSE.
REQ-024 digit_blank: ADJUST and blink high -> selected field's two bits set (sel=0: 1100, sel=1: 0011); PAUSE and blink high -> 1111; otherwise 0000; registered, same latency as REQ-015.

Reset
REQ-025 rst SHALL asynchronously force digits 00:00, state RUN, paused 0, rollover 0, digit_blank 0000, sync flops 0, previous-level flops 1.
REQ-026 Reset asserted mid-operation (any state) SHALL take effect without waiting for a clk edge; operation resumes in RUN after release.

Structure
REQ-027 Shared package alarm_pkg SHALL hold state encoding, BCD width (4), and field maximum (59).
REQ-028 Sub-module bcd_mod60 (two-digit BCD counter: inc enable, wrap pulse out, async reset) SHALL be instantiated once per field.

Verification
REQ-029 Reset, then 3 clk_1hz rising edges -> 00:03; each update exactly 3 clk edges (SYNC_STAGES=2) after the sampled edge.
REQ-030 adj=1 sel=0 then sel=1, set 59:58, adj=0, 2 clk_1hz edges -> 59:59 then 00:00; rollover high exactly one cycle.
REQ-031 adj=1 sel=1 from 00:00, 61 clk_fast edges plus 5 clk_1hz edges -> 00:01; minutes unchanged, rollover never high.
REQ-032 adj=1 sel=1 clk_blink=1 -> digit_blank=0011; sel=0 -> 1100; clk_blink=0 -> 0000.
REQ-033 RUN at 00:10, pause_pulse, 5 clk_1hz edges -> 00:10, digit_blank 1111 while clk_blink=1; second pause_pulse + 1 edge -> 00:11.
REQ-034 rst asserted mid-ADJUST between clk edges -> outputs 00:00 and digit_blank 0000 before next clk edge; clk_1hz held high at release -> no increment.

Source files
------------

// File: rtl/alarm_pkg.sv
// Shared definitions for the mm:ss time counter.
// Holds the state encoding, the BCD digit width and the field maximum.
package alarm_pkg;

    localparam int BCD_W     = 4;
    localparam int FIELD_MAX = 59;

    localparam logic [1:0] ST_RUN    = 2'd0;
    localparam logic [1:0] ST_PAUSE  = 2'd1;
    localparam logic [1:0] ST_ADJUST = 2'd2;

    localparam logic [3:0] BLANK_MIN = 4'b1100;
    localparam logic [3:0] BLANK_SEC = 4'b0011;
    localparam logic [3:0] BLANK_ALL = 4'b1111;

    typedef logic [BCD_W-1:0] bcd_t;

endpackage

// File: rtl/bcd_mod60.sv
// Two-digit BCD counter, 00..FIELD_MAX, with a combinational wrap
// pulse that is high when an increment takes the field back to 00.
module bcd_mod60
    import alarm_pkg::*;
(
    input  logic clk,
    input  logic rst,
    input  logic inc_i,
    output logic wrap_o,
    output bcd_t tens_o,
    output bcd_t ones_o
);

    localparam bcd_t MAX_T = bcd_t'(FIELD_MAX / 10);
    localparam bcd_t MAX_O = bcd_t'(FIELD_MAX % 10);

    bcd_t tens_q, tens_d;
    bcd_t ones_q, ones_d;
    logic at_max;

    assign at_max = (tens_q == MAX_T) && (ones_q == MAX_O);
    assign wrap_o = inc_i && at_max;
    assign tens_o = tens_q;
    assign ones_o = ones_q;

    always_comb begin
        tens_d = tens_q;
        ones_d = ones_q;
        if (inc_i) begin
            if (at_max) begin
                tens_d = '0;
                ones_d = '0;
            end else if (ones_q == bcd_t'(9)) begin
                tens_d = tens_q + bcd_t'(1);
                ones_d = '0;
            end else begin
                ones_d = ones_q + bcd_t'(1);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tens_q <= '0;
            ones_q <= '0;
        end else begin
            tens_q <= tens_d;
            ones_q <= ones_d;
        end
    end

endmodule

// File: rtl/time_counter.sv
// mm:ss counter with run/pause/adjust modes, driven by synchronised
// divided-clock levels sampled in the single clk domain.
module time_counter
    import alarm_pkg::*;
#(
    parameter int SYNC_STAGES = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clk_1hz,
    input  logic             clk_fast,
    input  logic             clk_blink,
    input  logic             adj,
    input  logic             sel,
    input  logic             pause_pulse,
    output logic [BCD_W-1:0] min_tens,
    output logic [BCD_W-1:0] min_ones,
    output logic [BCD_W-1:0] sec_tens,
    output logic [BCD_W-1:0] sec_ones,
    output logic [3:0]       digit_blank,
    output logic             rollover
);

    // lvl bits: 4=1hz 3=fast 2=blink 1=adj 0=sel
    logic [4:0]             sync_q [SYNC_STAGES];
    logic [4:0]             lvl;
    logic [SYNC_STAGES-1:0] fill_q;
    logic [1:0]             prev_q;

    logic       tick_1hz, tick_fast;
    logic       blink_s, adj_s, sel_s;
    logic [1:0] state_q, state_d;
    logic       paused_q, paused_d;
    logic [3:0] blank_q, blank_d;
    logic       roll_q, roll_d;
    logic       run, adjm;
    logic       sec_inc, min_inc, sec_wrap, min_wrap;

    assign lvl     = sync_q[SYNC_STAGES-1];
    assign blink_s = lvl[2];
    assign adj_s   = lvl[1];
    assign sel_s   = lvl[0];

    assign tick_1hz  = lvl[4] & ~prev_q[1];
    assign tick_fast = lvl[3] & ~prev_q[0];

    // prev holds at 1 until the chain has filled, so a level that is
    // already high at reset release is not mistaken for a rising edge
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= '0;
            fill_q <= '0;
            prev_q <= 2'b11;
        end else begin
            sync_q[0] <= {clk_1hz, clk_fast, clk_blink, adj, sel};
            for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
            fill_q <= {fill_q[SYNC_STAGES-2:0], 1'b1};
            if (fill_q[SYNC_STAGES-1]) prev_q <= lvl[4:3];
        end
    end

    always_comb begin
        state_d  = state_q;
        paused_d = paused_q;
        if (adj_s) begin
            state_d = ST_ADJUST;
        end else begin
            unique case (state_q)
                ST_ADJUST: state_d = paused_q ? ST_PAUSE : ST_RUN;
                ST_RUN: begin
                    if (pause_pulse) begin
                        state_d  = ST_PAUSE;
                        paused_d = 1'b1;
                    end
                end
                ST_PAUSE: begin
                    if (pause_pulse) begin
                        state_d  = ST_RUN;
                        paused_d = 1'b0;
                    end
                end
                default: state_d = ST_RUN;
            endcase
        end
    end

    assign run  = (state_q == ST_RUN);
    assign adjm = (state_q == ST_ADJUST);

    assign sec_inc = (run & tick_1hz) | (adjm & sel_s & tick_fast);
    assign min_inc = (run & tick_1hz & sec_wrap)
                   | (adjm & ~sel_s & tick_fast);
    assign roll_d  = run & tick_1hz & sec_wrap & min_wrap;

    // blank follows the next state so it lines up with the digits
    always_comb begin
        blank_d = '0;
        if (blink_s) begin
            unique case (state_d)
                ST_ADJUST: blank_d = sel_s ? BLANK_SEC : BLANK_MIN;
                ST_PAUSE:  blank_d = BLANK_ALL;
                default:   blank_d = '0;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= ST_RUN;
            paused_q <= 1'b0;
            blank_q  <= '0;
            roll_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            paused_q <= paused_d;
            blank_q  <= blank_d;
            roll_q   <= roll_d;
        end
    end

    bcd_mod60 u_sec (
        .clk    (clk),
        .rst    (rst),
        .inc_i  (sec_inc),
        .wrap_o (sec_wrap),
        .tens_o (sec_tens),
        .ones_o (sec_ones)
    );

    bcd_mod60 u_min (
        .clk    (clk),
        .rst    (rst),
        .inc_i  (min_inc),
        .wrap_o (min_wrap),
        .tens_o (min_tens),
        .ones_o (min_ones)
    );

    assign digit_blank = blank_q;
    assign rollover    = roll_q;

endmodule

// File: tb/tb_time_counter.sv
// Scoreboard bench for time_counter: an integer mm:ss model predicts
// each output change and the cycle it should appear on.
module tb_time_counter;
    import alarm_pkg::*;

    logic       clk = 1'b0;
    logic       rst;
    logic       clk_1hz, clk_fast, clk_blink, adj, sel, pause_pulse;
    logic [3:0] min_tens, min_ones, sec_tens, sec_ones, digit_blank;
    logic       rollover;
    logic [20:0] dut_v;

    time_counter #(.SYNC_STAGES(2)) dut (
        .clk         (clk),
        .rst         (rst),
        .clk_1hz     (clk_1hz),
        .clk_fast    (clk_fast),
        .clk_blink   (clk_blink),
        .adj         (adj),
        .sel         (sel),
        .pause_pulse (pause_pulse),
        .min_tens    (min_tens),
        .min_ones    (min_ones),
        .sec_tens    (sec_tens),
        .sec_ones    (sec_ones),
        .digit_blank (digit_blank),
        .rollover    (rollover)
    );

    assign dut_v = {min_tens, min_ones, sec_tens, sec_ones,
                    digit_blank, rollover};

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct { int at; logic [20:0] v; } exp_t;
    exp_t sb[$];
    int n_chk = 0;
    int n_fail = 0;

    typedef enum {M_RUN, M_PAUSE, M_ADJ} mode_t;
    mode_t mode;
    int m_min, m_sec;
    bit m_paused, m_adj, m_sel, m_blink;
    logic [20:0] last_v;

    function automatic logic [3:0] mblank();
        if (!m_blink) return 4'b0000;
        if (mode == M_ADJ) return m_sel ? 4'b0011 : 4'b1100;
        if (mode == M_PAUSE) return 4'b1111;
        return 4'b0000;
    endfunction

    function automatic logic [20:0] mvec(bit r);
        return {4'(m_min / 10), 4'(m_min % 10),
                4'(m_sec / 10), 4'(m_sec % 10), mblank(), r};
    endfunction

    task automatic expect_at(int at, bit r);
        logic [20:0] v;
        v = mvec(r);
        if (v !== last_v) begin
            sb.push_back('{at: at, v: v});
            last_v = v;
        end
    endtask

    task automatic model_reset();
        m_min = 0; m_sec = 0; mode = M_RUN;
        m_paused = 0; m_adj = 0; m_sel = 0; m_blink = 0;
        last_v = '0;
        sb.delete();
    endtask

    task automatic bump_1hz(output bit r);
        r = 0;
        if (mode == M_RUN) begin
            m_sec++;
            if (m_sec == 60) begin
                m_sec = 0;
                m_min++;
                if (m_min == 60) begin
                    m_min = 0;
                    r = 1;
                end
            end
        end
    endtask

    task automatic do_pause();
        if (mode != M_ADJ) begin
            m_paused = !m_paused;
            mode = m_paused ? M_PAUSE : M_RUN;
        end
    endtask

    task automatic settle(int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic tick1();
        bit r;
        int c;
        @(negedge clk);
        c = cyc;
        clk_1hz = 1'b1;
        bump_1hz(r);
        expect_at(c + 3, r);
        if (r) expect_at(c + 4, 1'b0);
        settle(3);
        clk_1hz = 1'b0;
        settle(3);
    endtask

    task automatic tickf();
        int c;
        @(negedge clk);
        c = cyc;
        clk_fast = 1'b1;
        if (mode == M_ADJ) begin
            if (m_sel) m_sec = (m_sec + 1) % 60;
            else m_min = (m_min + 1) % 60;
        end
        expect_at(c + 3, 1'b0);
        settle(3);
        clk_fast = 1'b0;
        settle(3);
    endtask

    // which: 0 = adj, 1 = sel, 2 = blink
    task automatic set_lvl(int which, bit v);
        int c;
        @(negedge clk);
        c = cyc;
        case (which)
            0: begin
                adj = v;
                m_adj = v;
                if (v) mode = M_ADJ;
                else if (mode == M_ADJ) mode = m_paused ? M_PAUSE : M_RUN;
            end
            1: begin sel = v; m_sel = v; end
            default: begin clk_blink = v; m_blink = v; end
        endcase
        expect_at(c + 3, 1'b0);
        settle(6);
    endtask

    task automatic pause_op();
        int c;
        @(negedge clk);
        c = cyc;
        pause_pulse = 1'b1;
        do_pause();
        expect_at(c + 1, 1'b0);
        @(negedge clk);
        pause_pulse = 1'b0;
        settle(5);
    endtask

    task automatic tick_pause();
        bit r;
        int c;
        @(negedge clk);
        c = cyc;
        clk_1hz = 1'b1;
        settle(2);
        pause_pulse = 1'b1;
        bump_1hz(r);
        do_pause();
        expect_at(c + 3, r);
        if (r) expect_at(c + 4, 1'b0);
        settle(1);
        pause_pulse = 1'b0;
        settle(2);
        clk_1hz = 1'b0;
        settle(3);
    endtask

    task automatic check_now(string name);
        @(negedge clk);
        n_chk++;
        if (dut_v !== mvec(1'b0)) begin
            n_fail++;
            $display("FAIL %s: got %h want %h", name, dut_v, mvec(1'b0));
        end
    endtask

    // Monitor: every output change must match the next predicted one
    initial begin
        logic [20:0] prev, cur;
        exp_t e;
        prev = 'x;
        forever begin
            @(negedge clk);
            cur = dut_v;
            if (rst) begin
                prev = cur;
            end else begin
                while (sb.size() > 0 && sb[0].at < cyc) begin
                    e = sb.pop_front();
                    n_chk++;
                    n_fail++;
                    $display("FAIL missed: got %h at cyc %0d, want %h at cyc %0d",
                             cur, cyc, e.v, e.at);
                end
                if (cur !== prev) begin
                    n_chk++;
                    if (sb.size() == 0) begin
                        n_fail++;
                        $display("FAIL unexpected: got %h at cyc %0d, want no change",
                                 cur, cyc);
                    end else begin
                        e = sb.pop_front();
                        if (e.v !== cur || e.at != cyc) begin
                            n_fail++;
                            $display("FAIL change: got %h at cyc %0d, want %h at cyc %0d",
                                     cur, cyc, e.v, e.at);
                        end
                    end
                    prev = cur;
                end
            end
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout, want completion");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1;
        clk_1hz = 0; clk_fast = 0; clk_blink = 0;
        adj = 0; sel = 0; pause_pulse = 0;
        model_reset();
        settle(3);
        n_chk++;
        if (dut_v !== 21'h0) begin
            n_fail++;
            $display("FAIL reset: got %h want %h", dut_v, 21'h0);
        end
        rst = 1'b0;
        settle(4);

        repeat (3) tick1();
        check_now("run_00_03");

        set_lvl(0, 1'b1);
        repeat (59) tickf();
        set_lvl(1, 1'b1);
        repeat (58) tickf();
        check_now("set_59_58");
        set_lvl(0, 1'b0);
        tick1();
        check_now("run_59_59");
        tick1();
        check_now("wrap_00_00");

        set_lvl(0, 1'b1);
        repeat (61) tickf();
        repeat (5) tick1();
        check_now("adj_sec_mod60");

        set_lvl(2, 1'b1);
        check_now("blank_sec");
        set_lvl(1, 1'b0);
        check_now("blank_min");
        set_lvl(2, 1'b0);
        check_now("blank_off");

        set_lvl(0, 1'b0);
        repeat (9) tick1();
        check_now("run_00_10");
        pause_op();
        set_lvl(2, 1'b1);
        repeat (5) tick1();
        check_now("paused_frozen");
        set_lvl(2, 1'b0);
        pause_op();
        tick1();
        check_now("resumed_00_11");

        tick_pause();
        check_now("tick_and_pause");
        pause_op();

        set_lvl(0, 1'b1);
        set_lvl(2, 1'b1);
        repeat (3) tickf();
        check_now("pre_async_rst");
        @(posedge clk);
        #2;
        rst = 1'b1;
        clk_1hz = 1; clk_fast = 0; clk_blink = 0; adj = 0; sel = 0;
        #1;
        n_chk++;
        if (dut_v !== 21'h0) begin
            n_fail++;
            $display("FAIL async_rst: got %h want %h", dut_v, 21'h0);
        end
        model_reset();
        settle(3);
        @(posedge clk);
        #3;
        rst = 1'b0;
        settle(8);
        clk_1hz = 1'b0;
        settle(4);
        check_now("no_spurious_tick");
        tick1();
        check_now("resume_after_rst");

        for (int i = 0; i < 300; i++) begin
            int r;
            r = $urandom_range(0, 9);
            if (r <= 3) tick1();
            else if (r <= 5) tickf();
            else if (r == 6) set_lvl(0, !m_adj);
            else if (r == 7) set_lvl(1, !m_sel);
            else if (r == 8) set_lvl(2, !m_blink);
            else pause_op();
        end
        check_now("random_final");

        settle(6);
        n_chk++;
        if (sb.size() != 0) begin
            n_fail++;
            $display("FAIL drain: got %0d pending want 0", sb.size());
        end

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
